// File: rtl/nios2_oci_mem_cmd_pkg.sv
// Shared definitions for the OCI debug-memory command block.
//   - mem_state_e         : command FSM states (IDLE, RD, WR)
//   - jdo field positions : address lsb, read-now bit, clear-error bit, write-data lsb
//   - ERR_PATTERN_DEFAULT : MonDReg value loaded when a read is aborted
package nios2_oci_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mem_state_e;

  localparam int ADDR_LSB    = 17;
  localparam int RD_NOW_BIT  = 34;
  localparam int CLR_ERR_BIT = 35;
  localparam int WDATA_LSB   = 3;

  localparam logic [31:0] ERR_PATTERN_DEFAULT = 32'hDEADDEAD;

endpackage

// File: rtl/nios2_oci_mem_cmd_if.sv
// Word-wide request/acknowledge port to the on-chip debug memory.
//   mem_addr  : word address (ADDR_W bits), driven by master
//   mem_wdata : write data, driven by master
//   mem_rd    : read request, held until mem_ack
//   mem_wr    : write request, held until mem_ack
//   mem_ack   : request complete, driven by slave
//   mem_rdata : read data, valid in the mem_ack cycle
// Modports: master (command block side), slave (memory side).
interface nios2_oci_mem_cmd_if #(
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/nios2_oci_mem_cmd_timeout.sv
// Request watchdog for the debug-memory command block.
// Built only when OCI_MEM_TIMEOUT_EN is defined.
//   clk, reset : clock and synchronous active-high reset
//   load       : a request is being issued; restart the count from zero
//   run        : a request is outstanding
//   expire     : high in the TIMEOUT-th cycle of an outstanding request
module nios2_oci_mem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  // Count starts at 0 in the first request cycle, so cnt_q == TIMEOUT-1
  // marks the TIMEOUT-th cycle the request has been held.
  assign expire = run && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt_q <= '0;
    end else if (run && !expire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nios2_oci_mem_cmd.sv
// Decodes JTAG debug-slave commands into single word reads/writes on the
// on-chip debug memory, one command outstanding, auto-incrementing address.
// Optional feature macro: OCI_MEM_TIMEOUT_EN (abort a request that is not
// acknowledged within TIMEOUT cycles).
//   clk, reset              : clock, synchronous active-high reset
//   jdo[37:0]               : JTAG data-out word
//   take_action_ocimem_a    : load address / read_now / clear_error
//   take_no_action_ocimem_a : read at current address, then increment
//   take_action_ocimem_b    : write jdo[34:3] at current address, then increment
//   mem                     : debug-memory request port (master)
//   MonDReg                 : last read data
//   monitor_ready           : 1 = idle, MonDReg valid
//   monitor_error           : sticky overrun / timeout flag
module nios2_oci_mem_cmd
  import nios2_oci_mem_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_PATTERN = ERR_PATTERN_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [37:0]         jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  nios2_oci_mem_cmd_if.master mem,
  output logic [31:0]         MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error
);

  if (ADDR_W < 1 || ADDR_W > 17 || TIMEOUT < 1) begin : g_bad_cfg
    $error("nios2_oci_mem_cmd: ADDR_W must be 1..17 and TIMEOUT >= 1");
  end

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rd_inc_q;

  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic              any_strobe;
  logic              busy;
  logic              timeout_hit;
  logic              done;
  logic              err_set;
  logic              err_clr;
  logic              unused_jdo;

  assign jdo_addr   = jdo[ADDR_LSB +: ADDR_W];
  assign jdo_wdata  = jdo[WDATA_LSB +: 32];
  assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign busy       = (state_q != IDLE);
  assign done       = busy && (mem.mem_ack || timeout_hit);

  // A strobe arriving while a request is outstanding is an overrun; an
  // acknowledge in the expiry cycle still completes the request normally.
  assign err_set = busy && (any_strobe || (timeout_hit && !mem.mem_ack));
  assign err_clr = !busy && take_action_ocimem_a && jdo[CLR_ERR_BIT];

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_rd    = (state_q == RD);
  assign mem.mem_wr    = (state_q == WR);

`ifdef OCI_MEM_TIMEOUT_EN
  logic tmo_load;
  logic tmo_expire;

  assign tmo_load    = !busy && (state_d != IDLE);
  assign timeout_hit = tmo_expire;

  nios2_oci_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (tmo_load),
    .run    (busy),
    .expire (tmo_expire)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state: strobe priority is action_a > action_b > no_action_a.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          if (jdo[RD_NOW_BIT]) state_d = RD;
        end else if (take_action_ocimem_b) begin
          state_d = WR;
        end else if (take_no_action_ocimem_a) begin
          state_d = RD;
        end
      end
      RD, WR: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage boundary: command accept in IDLE, completion on ack or expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_inc_q      <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      if (!busy) begin
        if (take_action_ocimem_a) begin
          addr_q <= jdo_addr;
          if (jdo[RD_NOW_BIT]) begin
            rd_inc_q      <= 1'b0;
            monitor_ready <= 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          wdata_q       <= jdo_wdata;
          monitor_ready <= 1'b0;
        end else if (take_no_action_ocimem_a) begin
          rd_inc_q      <= 1'b1;
          monitor_ready <= 1'b0;
        end
      end else if (done) begin
        monitor_ready <= 1'b1;
        if (state_q == RD) begin
          MonDReg <= mem.mem_ack ? mem.mem_rdata : ERR_PATTERN;
        end
        if (state_q == WR || rd_inc_q) begin
          addr_q <= next_addr(addr_q);
        end
      end

      if (err_set) begin
        monitor_error <= 1'b1;
      end else if (err_clr) begin
        monitor_error <= 1'b0;
      end
    end
  end

endmodule
